// File: rtl/cam_pkg.sv
// Shared types and constants for the DVP capture front-end.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2
    } cam_state_t;

    localparam int BIDX_W = 2;

    function automatic bit bpp_legal(input int bpp);
        return (bpp >= 1) && (bpp <= 3);
    endfunction

endpackage

// File: rtl/cam_pix_pack.sv
// Byte shifter and byte index for one pixel; flags the byte that completes a pixel.
module cam_pix_pack
    import cam_pkg::*;
#(
    parameter int DIN_W         = 8,
    parameter int BYTES_PER_PIX = 2
) (
    input  logic                             ov5640_pclk,
    input  logic                             sys_rst_n,
    input  logic                             en,
    input  logic                             clr,
    input  logic [DIN_W-1:0]                 din,
    output logic [DIN_W*BYTES_PER_PIX-1:0]   word,
    output logic                             done,
    output logic                             partial
);

    localparam int                PIX_W = DIN_W * BYTES_PER_PIX;
    localparam logic [BIDX_W-1:0] LAST  = BIDX_W'(BYTES_PER_PIX - 1);

    logic [PIX_W-1:0]  shift;
    logic [BIDX_W-1:0] byte_idx;

    // Older bytes fall off the top, so the first byte of a pixel ends up in the MSBs.
    assign word    = PIX_W'({shift, din});
    assign done    = en && (byte_idx == LAST);
    assign partial = (byte_idx != '0);

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift    <= '0;
            byte_idx <= '0;
        end else begin
            if (en) shift <= word;
            if (clr)
                byte_idx <= '0;
            else if (en)
                byte_idx <= (byte_idx == LAST) ? '0 : byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cam_dvp_capture.sv
// DVP capture: input registers, frame-skip/capture FSM, pixel framing and geometry check.
// Optional crop window is built in when CAM_CROP_EN is defined.
//   state | meaning
//   WAIT  | discarding start-up frames until PIC_WAIT vsync edges are seen
//   IDLE  | armed; waits for a vsync edge with cap_en=1
//   FRAME | capturing; the next vsync edge closes and possibly reopens the frame
module cam_dvp_capture
    import cam_pkg::*;
#(
    parameter int DIN_W         = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int PIC_WAIT      = 10,
    parameter int H_ACT         = 1280,
    parameter int V_ACT         = 720,
    parameter int CNT_W         = 12
`ifdef CAM_CROP_EN
    ,
    parameter int CROP_X0       = 0,
    parameter int CROP_Y0       = 0,
    parameter int CROP_W        = H_ACT,
    parameter int CROP_H        = V_ACT
`endif
) (
    input  logic                            ov5640_pclk,
    input  logic                            sys_rst_n,
    input  logic                            cam_href,
    input  logic                            cam_vsync,
    input  logic [DIN_W-1:0]                cam_data,
    input  logic                            cap_en,
    output logic                            pix_valid,
    output logic [DIN_W*BYTES_PER_PIX-1:0]  pix_data,
    output logic                            pix_sof,
    output logic                            pix_eol,
    output logic                            frame_done,
    output logic                            frame_err,
    output logic [CNT_W-1:0]                line_cnt,
    output logic                            cam_hs,
    output logic                            cam_vs
);

    if (!bpp_legal(BYTES_PER_PIX)) begin : g_bad_bpp
        $error("cam_dvp_capture: BYTES_PER_PIX must be 1..3");
    end

    localparam int               SKIP_W  = (PIC_WAIT < 1) ? 1 : $clog2(PIC_WAIT + 1);
    localparam logic [SKIP_W-1:0] SKIP_TC = SKIP_W'(PIC_WAIT);
    localparam logic [CNT_W-1:0]  H_ACT_C = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0]  V_ACT_C = CNT_W'(V_ACT);

    logic             href_r, href_d, vsync_r, vsync_d;
    logic [DIN_W-1:0] data_r;
    logic             vsync_rise, href_fall;

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            href_r  <= 1'b0;
            href_d  <= 1'b0;
            vsync_r <= 1'b0;
            vsync_d <= 1'b0;
            data_r  <= '0;
        end else begin
            href_r  <= cam_href;
            href_d  <= href_r;
            vsync_r <= cam_vsync;
            vsync_d <= vsync_r;
            data_r  <= cam_data;
        end
    end

    assign vsync_rise = vsync_r & ~vsync_d;
    assign href_fall  = href_d & ~href_r;
    assign cam_hs     = href_d;
    assign cam_vs     = vsync_d;

    cam_state_t        state, state_n;
    logic [SKIP_W-1:0] skip_cnt;
    logic              frame_start, frame_close;

    always_comb begin
        state_n     = state;
        frame_start = 1'b0;
        frame_close = 1'b0;
        case (state)
            ST_WAIT:  if (skip_cnt == SKIP_TC) state_n = ST_IDLE;
            ST_IDLE:  if (vsync_rise && cap_en) begin
                          state_n     = ST_FRAME;
                          frame_start = 1'b1;
                      end
            ST_FRAME: if (vsync_rise) begin
                          frame_close = 1'b1;
                          if (cap_en) frame_start = 1'b1;
                          else        state_n     = ST_IDLE;
                      end
            default:  state_n = ST_WAIT;
        endcase
    end

    logic                           in_frame, eol_evt, pack_en, pack_clr;
    logic                           pix_done, partial;
    logic [DIN_W*BYTES_PER_PIX-1:0] pix_word;
    logic [CNT_W-1:0]               pix_cnt, line_cnt_eff;
    logic                           line_err, line_err_eff, sof_pend;
    logic                           win_x, win_y, emit;

    assign in_frame = (state == ST_FRAME);
    assign eol_evt  = in_frame & href_fall;
    // Bytes arriving on the frame-boundary cycle belong to neither frame.
    assign pack_en  = in_frame & href_r & ~vsync_rise;
    assign pack_clr = href_fall | vsync_rise;

    cam_pix_pack #(
        .DIN_W         (DIN_W),
        .BYTES_PER_PIX (BYTES_PER_PIX)
    ) u_pack (
        .ov5640_pclk (ov5640_pclk),
        .sys_rst_n   (sys_rst_n),
        .en          (pack_en),
        .clr         (pack_clr),
        .din         (data_r),
        .word        (pix_word),
        .done        (pix_done),
        .partial     (partial)
    );

`ifdef CAM_CROP_EN
    localparam logic [CNT_W:0] X0 = (CNT_W+1)'(CROP_X0);
    localparam logic [CNT_W:0] X1 = (CNT_W+1)'(CROP_X0 + CROP_W);
    localparam logic [CNT_W:0] Y0 = (CNT_W+1)'(CROP_Y0);
    localparam logic [CNT_W:0] Y1 = (CNT_W+1)'(CROP_Y0 + CROP_H);
    assign win_x = ({1'b0, pix_cnt} >= X0) && ({1'b0, pix_cnt} < X1);
    assign win_y = ({1'b0, line_cnt} >= Y0) && ({1'b0, line_cnt} < Y1);
`else
    assign win_x = 1'b1;
    assign win_y = 1'b1;
`endif
    assign emit = pix_done & win_x & win_y;

    // A line ending on the closing vsync edge is folded in before the frame is judged.
    assign line_cnt_eff = (eol_evt && line_cnt != '1) ? line_cnt + 1'b1 : line_cnt;
    assign line_err_eff = line_err | (eol_evt & ((pix_cnt != H_ACT_C) | partial));

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_WAIT;
            skip_cnt   <= '0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            line_err   <= 1'b0;
            sof_pend   <= 1'b0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ST_WAIT && vsync_rise && skip_cnt != SKIP_TC)
                skip_cnt <= skip_cnt + 1'b1;

            if (frame_start || href_fall)
                pix_cnt <= '0;
            else if (pix_done && pix_cnt != '1)
                pix_cnt <= pix_cnt + 1'b1;

            line_cnt <= frame_start ? '0   : line_cnt_eff;
            line_err <= frame_start ? 1'b0 : line_err_eff;

            if (frame_start)      sof_pend <= 1'b1;
            else if (frame_close) sof_pend <= 1'b0;
            else if (emit)        sof_pend <= 1'b0;

            pix_valid <= emit;
            pix_sof   <= emit & sof_pend;
            if (emit) pix_data <= pix_word;
            pix_eol   <= eol_evt & win_y;

            // frame_err is only meaningful alongside frame_done and is zero otherwise.
            frame_done <= frame_close;
            frame_err  <= frame_close & ((line_cnt_eff != V_ACT_C) | line_err_eff);
        end
    end

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Directed bench for cam_dvp_capture: 4x3 RGB565 frames, frame-level vector table plus packing and reset sequences.
module tb_cam_dvp_capture;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        cam_href, cam_vsync, cap_en;
    logic [7:0]  cam_data;
    logic        pix_valid, pix_sof, pix_eol, frame_done, frame_err, cam_hs, cam_vs;
    logic [15:0] pix_data;
    logic [3:0]  line_cnt;

    always #5 clk = ~clk;

    cam_dvp_capture #(
        .DIN_W         (8),
        .BYTES_PER_PIX (2),
        .PIC_WAIT      (2),
        .H_ACT         (4),
        .V_ACT         (3),
        .CNT_W         (4)
`ifdef CAM_CROP_EN
        ,
        .CROP_X0       (1),
        .CROP_Y0       (1),
        .CROP_W        (2),
        .CROP_H        (2)
`endif
    ) dut (
        .ov5640_pclk (clk),
        .sys_rst_n   (sys_rst_n),
        .cam_href    (cam_href),
        .cam_vsync   (cam_vsync),
        .cam_data    (cam_data),
        .cap_en      (cap_en),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .line_cnt    (line_cnt),
        .cam_hs      (cam_hs),
        .cam_vs      (cam_vs)
    );

    int checks   = 0;
    int failures = 0;
    int tot_pix = 0, tot_eol = 0, tot_sof = 0, tot_done = 0, tot_err = 0;

    always @(negedge clk) begin
        tot_pix  <= tot_pix  + int'(pix_valid);
        tot_eol  <= tot_eol  + int'(pix_eol);
        tot_sof  <= tot_sof  + int'(pix_sof);
        tot_done <= tot_done + int'(frame_done);
        tot_err  <= tot_err  + int'(frame_done & frame_err);
    end

    typedef struct {
        bit cap;
        bit drop;
        int lines;
        int l1_bytes;
        int pix;
        int eol;
        int cpix;
        int ceol;
        int done;
        int err;
        int lcnt;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(bit cap, bit drop, int lines, int l1, int pix, int eol,
                                int cpix, int ceol, int done, int err, int lcnt);
        vec_t v;
        v.cap = cap; v.drop = drop; v.lines = lines; v.l1_bytes = l1;
        v.pix = pix; v.eol = eol; v.cpix = cpix; v.ceol = ceol;
        v.done = done; v.err = err; v.lcnt = lcnt;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vsync();
        cam_vsync = 1'b1;
        repeat (2) step();
        cam_vsync = 1'b0;
        repeat (3) step();
    endtask

    task automatic drive_line(input int nbytes, input int seed);
        for (int i = 0; i < nbytes; i++) begin
            cam_href = 1'b1;
            cam_data = 8'(seed + i);
            step();
        end
        cam_href = 1'b0;
        repeat (4) step();
    endtask

    // One frame: vsync (which closes the previous frame) then the lines; done/err refer to the previous frame.
    task automatic run_vec(input int idx);
        vec_t v;
        int p0, e0, s0, d0, r0, xp, xe;
        v  = vecs[idx];
        cap_en = v.cap;
        p0 = tot_pix; e0 = tot_eol; s0 = tot_sof; d0 = tot_done; r0 = tot_err;
        drive_vsync();
        for (int l = 0; l < v.lines; l++) begin
            drive_line((l == 1) ? v.l1_bytes : 8, 16 * l + idx);
            if (v.drop && l == 0) cap_en = 1'b0;
        end
        repeat (3) step();
`ifdef CAM_CROP_EN
        xp = v.cpix; xe = v.ceol;
`else
        xp = v.pix;  xe = v.eol;
`endif
        check($sformatf("v%0d_pix_valid", idx), tot_pix - p0, xp);
        check($sformatf("v%0d_pix_eol", idx), tot_eol - e0, xe);
        check($sformatf("v%0d_pix_sof", idx), tot_sof - s0, (xp > 0) ? 1 : 0);
        check($sformatf("v%0d_prev_done", idx), tot_done - d0, v.done);
        check($sformatf("v%0d_prev_err", idx), tot_err - r0, v.err);
        if (v.lcnt >= 0) check($sformatf("v%0d_line_cnt", idx), int'(line_cnt), v.lcnt);
    endtask

    logic [7:0] pk[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          cap drop ln l1  pix eol cpix ceol done err lcnt
        vecs[0]  = mk(1, 0, 3, 8,  0, 0, 0, 0, 0, 0, -1);
        vecs[1]  = mk(1, 0, 3, 8,  0, 0, 0, 0, 0, 0, -1);
        vecs[2]  = mk(1, 0, 3, 8, 12, 3, 4, 2, 0, 0,  3);
        vecs[3]  = mk(1, 0, 3, 8, 12, 3, 4, 2, 1, 0,  3);
        vecs[4]  = mk(1, 0, 3, 7, 11, 3, 4, 2, 1, 0,  3);
        vecs[5]  = mk(1, 0, 3, 8, 12, 3, 4, 2, 1, 1,  3);
        vecs[6]  = mk(1, 1, 3, 8, 12, 3, 4, 2, 1, 0,  3);
        vecs[7]  = mk(0, 0, 3, 8,  0, 0, 0, 0, 1, 0, -1);
        vecs[8]  = mk(1, 0, 3, 8, 12, 3, 4, 2, 0, 0,  3);
        vecs[9]  = mk(1, 0, 4, 8, 16, 4, 4, 2, 1, 0,  4);
        vecs[10] = mk(1, 0, 3, 8, 12, 3, 4, 2, 1, 1,  3);
        vecs[11] = mk(1, 0, 2, 8,  8, 2, 2, 1, 1, 0,  2);
        vecs[12] = mk(1, 0, 3, 8, 12, 3, 4, 2, 1, 1,  3);
        vecs[13] = mk(1, 0, 3, 8, 12, 3, 4, 2, 1, 0,  3);
        vecs[14] = mk(1, 0, 3, 8,  0, 0, 0, 0, 0, 0, -1);
        vecs[15] = mk(1, 0, 3, 8,  0, 0, 0, 0, 0, 0, -1);
        vecs[16] = mk(1, 0, 3, 8, 12, 3, 4, 2, 0, 0,  3);
        vecs[17] = mk(1, 0, 0, 8,  0, 0, 0, 0, 1, 0, -1);

        sys_rst_n = 1'b0;
        cam_href  = 1'b0;
        cam_vsync = 1'b0;
        cam_data  = 8'h00;
        cap_en    = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("reset_flags", int'({pix_valid, pix_sof, pix_eol, frame_done, frame_err, cam_hs, cam_vs}), 0);
        check("reset_line_cnt", int'(line_cnt), 0);
        check("reset_pix_data", int'(pix_data), 0);
        step();
        sys_rst_n = 1'b1;
        step();

        for (int i = 0; i <= 12; i++) run_vec(i);

        // Packing: AB CD 12 34 56 78 9A BC as the first line of a frame
        pk = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        cap_en = 1'b1;
        drive_vsync();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                cam_href = 1'b1;
                cam_data = pk[i];
            end else begin
                cam_href = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
`ifndef CAM_CROP_EN
            check($sformatf("pack%0d_valid", i), int'(pix_valid), (i >= 2 && i % 2 == 0) ? 1 : 0);
            check($sformatf("pack%0d_sof", i), int'(pix_sof), (i == 2) ? 1 : 0);
            if (i >= 2 && i % 2 == 0)
                check($sformatf("pack%0d_data", i), int'(pix_data), int'({pk[i-2], pk[i-1]}));
`endif
        end
        repeat (3) step();
        drive_line(8, 8'h20);
        drive_line(8, 8'h30);
        run_vec(13);

        // Reset in the middle of the second line of a captured frame
        drive_vsync();
        drive_line(8, 8'h40);
        cam_href = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cam_data = 8'(8'h50 + i);
            step();
        end
        @(negedge clk);
        check("pre_rst_line_cnt", int'(line_cnt), 1);
        sys_rst_n = 1'b0;
        #1;
        check("rst_async_flags", int'({pix_valid, pix_sof, pix_eol, frame_done, frame_err, cam_hs, cam_vs}), 0);
        check("rst_async_line_cnt", int'(line_cnt), 0);
        check("rst_async_pix_data", int'(pix_data), 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_flags", int'({pix_valid, pix_sof, pix_eol, frame_done, frame_err, cam_hs, cam_vs}), 0);
        cam_href = 1'b0;
        step();
        sys_rst_n = 1'b1;
        step();
        for (int i = 14; i <= 17; i++) run_vec(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_dvp_capture.md
Name: cam_dvp_capture

Overview:
- Parametrised DVP camera capture front-end; successor to the fixed 8-to-16-bit OV5640 packer.
- Samples the camera byte bus on ov5640_pclk and packs 1–3 bytes per pixel.
- Skips a programmable number of start-up frames, counted on real VSYNC edges.
- Emits framed pixel strobes (SOF/EOL) and a per-frame geometry check to the write-FIFO / frame-buffer path.

Parameters:
DIN_W, 8, camera data bus width
BYTES_PER_PIX, 2, bytes per pixel; legal 1..3 (RAW8 / RGB565 / RGB888)
PIC_WAIT, 10, whole frames discarded after reset before capture is allowed
H_ACT, 1280, expected pixels per line
V_ACT, 720, expected lines per frame
CNT_W, 12, width of pixel/line counters; must satisfy 2**CNT_W > max(H_ACT, V_ACT)

Ports:
ov5640_pclk  in  1  camera pixel clock; sole clock
sys_rst_n  in  1  asynchronous active-low reset
cam_href  in  1  line valid, active high
cam_vsync  in  1  frame sync; rising edge = frame boundary
cam_data  in  DIN_W  camera byte
cap_en  in  1  capture enable; takes effect at frame boundaries only
pix_valid  out  1  one-cycle pixel strobe
pix_data  out  DIN_W*BYTES_PER_PIX  packed pixel; first byte in the MSBs
pix_sof  out  1  high with the first pix_valid of a frame
pix_eol  out  1  one-cycle pulse at each href falling edge in an active frame
frame_done  out  1  one-cycle pulse at the frame-ending vsync rising edge
frame_err  out  1  qualifies frame_done; 1 = geometry mismatch
line_cnt  out  CNT_W  lines completed in the current frame
cam_hs, cam_vs  out  1  href/vsync delayed by 2 pclk, for downstream timing

Behaviour:
- Reset and the reset value of all outputs:
  - Reset value of every output is 0. pix_data holds its last value when pix_valid=0.
- Input registering and edge detection:
  - Inputs are registered once.
  - vsync_rise and href_fall are detected on the registered copies against a further delayed copy.
- FSM states and transitions:
  - WAIT: counts vsync_rise up to PIC_WAIT; when the count is reached, go to IDLE.
  - IDLE: at vsync_rise with cap_en=1, go to FRAME. Clear line_cnt, the error flag and the pixel counter.
  - FRAME: pack and emit pixels. At the next vsync_rise:
    - pulse frame_done, with frame_err = (line_cnt!=V_ACT) | line_err_sticky;
    - if cap_en=1, start a new FRAME in the same cycle (counters cleared);
    - otherwise go to IDLE.
  - cap_en dropping mid-frame does not truncate the frame.
- Packing:
  - While the registered href=1 in FRAME, byte_idx counts 0..BYTES_PER_PIX-1 and shifts bytes in.
  - On the last byte, the pixel is registered: pix_valid is high 1 cycle after the last byte is registered (2 pclk after pin).
  - BYTES_PER_PIX=1 gives one pixel per byte.
- End of line:
  - At href_fall: pix_eol pulses; line_cnt increments (saturates at all-ones).
  - If pixel count != H_ACT, set line_err_sticky. Then clear the pixel counter and byte_idx.
  - A partial pixel at href fall is discarded and also sets line_err_sticky.
- Boundary conditions:
  - href high at vsync_rise: the frame is closed as normal and the line is not counted.
  - href_fall and vsync_rise in the same cycle: pix_eol is issued and line_cnt is updated before the comparison.
- Reset mid-frame: everything clears and the FSM returns to WAIT with the skip counter at 0.
- cam_hs/cam_vs are 2-stage shift registers, independent of the FSM.

Optional Feature:
- Macro CAM_CROP_EN.
  - When defined: parameters CROP_X0, CROP_Y0, CROP_W, CROP_H (defaults 0, 0, H_ACT, V_ACT) take effect.
    - pix_valid is suppressed outside x∈[CROP_X0, CROP_X0+CROP_W) and y∈[CROP_Y0, CROP_Y0+CROP_H).
    - pix_sof marks the first in-window pixel.
    - pix_eol pulses only for in-window lines.
    - Geometry checking still uses the full H_ACT/V_ACT.
  - When undefined: no crop logic; every packed pixel is emitted.

Decomposition:
- Package cam_pkg holds:
  - the FSM state enum (WAIT, IDLE, FRAME);
  - the byte-index width constant (2 bits);
  - the legal BYTES_PER_PIX range check.
- One sub-module, cam_pix_pack: the byte shifter plus byte_idx, with clear-on-href_fall and a pixel-complete strobe.

Test Plan:
- Skip frames: PIC_WAIT=2, 4 frames of 4x3 RGB565 with cap_en=1 -> no pix_valid in frames 1–2; frames 3 and 4 each give 12 pix_valid, 3 pix_eol and frame_done with frame_err=0.
- Packing: bytes 0xAB,0xCD then 0x12,0x34 -> pix_data=0xABCD, then 0x1234. First strobe arrives 2 pclk after 0xCD is on the pins, and pix_sof=1 only on 0xABCD.
- Short line: line 2 has 7 bytes (3.5 pixels) with H_ACT=4 -> 3 pix_valid on that line; frame_done with frame_err=1. The next good frame gives frame_err=0.
- cap_en drop: deassert cap_en mid-frame -> the rest of that frame is emitted and frame_done is pulsed; no pix_valid in the following frame.
- Reset: assert sys_rst_n=0 mid-line -> all outputs 0 next edge; after release, PIC_WAIT frames are skipped again.
- CAM_CROP_EN: crop 2x2 at (1,1) of a 4x3 frame -> exactly 4 pix_valid (pixels (1,1),(2,1),(1,2),(2,2)) and 2 pix_eol.
